// File: rtl/beta_mem_arbiter.sv
// Shares one single-ported memory between the Beta fetch (i_*) and data (d_*) ports.
// Data wins by default; a starvation counter forces a fetch after STARVE_MAX data grants.
// Optional BETA_ARB_TIMEOUT_EN adds an m_ready watchdog and a sticky err flag.
module beta_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_req,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  input  logic              d_re,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  output logic              m_re,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
  } memReq_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t   state, nextState;
  memReq_t  grantReq;
  logic [3:0] starveCnt;
  logic     dReq, grantD, grantI, busy, done, abort;

  assign dReq = d_we | d_re;
  assign busy = (state == IBUSY) || (state == DBUSY);
  assign done = busy && m_ready;

`ifdef BETA_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] waitCnt;

  // waitCnt counts completed strobe cycles; abort fires on the TIMEOUT-th one
  assign abort = busy && !m_ready && (waitCnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst || !busy || m_ready || abort) waitCnt <= '0;
    else                                   waitCnt <= waitCnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst)       err <= 1'b0;
    else if (abort) err <= 1'b1;
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    grantD    = 1'b0;
    grantI    = 1'b0;
    grantReq  = '0;
    case (state)
      IDLE: begin
        if (dReq && (!i_req || starveCnt < STARVE_LIM)) begin
          grantD    = 1'b1;
          nextState = DBUSY;
          // a simultaneous load+store is treated as a store
          grantReq  = '{addr: d_addr, wdata: d_wdata, we: d_we, re: d_re & ~d_we};
        end else if (i_req) begin
          grantI    = 1'b1;
          nextState = IBUSY;
          grantReq  = '{addr: i_addr, wdata: m_wdata, we: 1'b0, re: 1'b1};
        end
      end
      IBUSY, DBUSY: if (done || abort) nextState = RESP;
      RESP:         nextState = IDLE;
      default:      nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_addr    <= '0;
      m_wdata   <= '0;
      m_we      <= 1'b0;
      m_re      <= 1'b0;
      i_data    <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      starveCnt <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grantD || grantI) begin
        m_addr  <= grantReq.addr;
        m_wdata <= grantReq.wdata;
        m_we    <= grantReq.we;
        m_re    <= grantReq.re;
      end
      if (grantD && i_req && starveCnt < STARVE_LIM) starveCnt <= starveCnt + 4'd1;
      else if (grantI)                               starveCnt <= '0;
      if (done || abort) begin
        m_we <= 1'b0;
        m_re <= 1'b0;
        if (state == IBUSY) begin
          i_ready <= 1'b1;
          i_data  <= abort ? '1 : m_rdata;
        end else begin
          d_ready <= 1'b1;
          // stores leave d_rdata alone unless the access was aborted
          if (m_re || abort) d_rdata <= abort ? '1 : m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Self-checking bench for beta_mem_arbiter: vector table, hand sequences, and a
// randomized run against a transaction-level arbitration/memory model.
module tb_beta_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, i_data, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_req, i_ready, d_we, d_re, d_ready, m_we, m_re, m_ready, err;

  int tests  = 0;
  int failed = 0;

  beta_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_req(i_req), .i_data(i_data), .i_ready(i_ready),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_re(d_re),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    i_req = 0; i_addr = 0; d_we = 0; d_re = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rdata = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 0;
    idleInputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  typedef struct {
    logic        iReq, dWe, dRe;
    logic [31:0] addr, wdata, rdata;
    int          lat;
    logic        expD, expWe, expRe;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[6];

  // random-run model state
  logic [31:0] mem[16];
  bit          iPend, dPend, dWeR, dReR, grantExp, grantDExp, accActive, accD, accWe;
  bit          expIP, expDP, respNow, busyNow, idleNow;
  logic [31:0] iAddrR, dAddrR, dWdR, accAddr, accWd, iHeld, dHeld;
  int          streak, waitLeft;

  initial begin
    // reset with busy-looking inputs: every output must stay 0
    rst = 0;
    i_req = 1; i_addr = 32'h100; d_we = 1; d_re = 1; d_addr = 32'h200; d_wdata = 32'hFFFF_FFFF;
    m_ready = 1; m_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("rst m_addr", m_addr, 0);   check("rst m_wdata", m_wdata, 0);
    check("rst m_we", m_we, 0);       check("rst m_re", m_re, 0);
    check("rst i_data", i_data, 0);   check("rst d_rdata", d_rdata, 0);
    check("rst i_ready", i_ready, 0); check("rst d_ready", d_ready, 0);
    check("rst err", err, 0);
    idleInputs();
    rst = 1;

    // ---------------- table-driven single accesses ----------------
    vecs[0] = '{1, 0, 0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 0, 0, 1, 32'h1234_5678};
    vecs[1] = '{0, 0, 1, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 5, 1, 0, 1, 32'hCAFE_F00D};
    vecs[2] = '{0, 1, 0, 32'h0000_0300, 32'hA5A5_A5A5, 32'h5555_5555, 2, 1, 1, 0, 32'hCAFE_F00D};
    vecs[3] = '{0, 1, 1, 32'h0000_0304, 32'h1111_2222, 32'h6666_6666, 1, 1, 1, 0, 32'hCAFE_F00D};
    vecs[4] = '{1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, 1, 32'hDEAD_BEEF};
    vecs[5] = '{0, 0, 1, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1, 1, 0, 1, 32'h0BAD_F00D};

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      i_req = vecs[v].iReq; i_addr = vecs[v].addr;
      d_we = vecs[v].dWe; d_re = vecs[v].dRe; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      m_ready = 0;
      @(negedge clk);
      for (int k = 1; k <= vecs[v].lat; k++) begin
        check("vec m_addr", m_addr, vecs[v].addr);
        check("vec m_we", m_we, vecs[v].expWe);
        check("vec m_re", m_re, vecs[v].expRe);
        if (vecs[v].expWe) check("vec m_wdata", m_wdata, vecs[v].wdata);
        check("vec early ready", i_ready | d_ready, 0);
        if (k == vecs[v].lat) begin m_ready = 1; m_rdata = vecs[v].rdata; end
        @(negedge clk);
      end
      m_ready = 0; m_rdata = 32'h0F0F_0F0F;
      check("vec i_ready", i_ready, !vecs[v].expD);
      check("vec d_ready", d_ready, vecs[v].expD);
      check("vec resp strobes", m_we | m_re, 0);
      check("vec data", vecs[v].expD ? d_rdata : i_data, vecs[v].expData);
      i_req = 0; d_we = 0; d_re = 0;
      @(negedge clk);
      check("vec ready pulse width", i_ready | d_ready, 0);
      check("vec data held", vecs[v].expD ? d_rdata : i_data, vecs[v].expData);
    end

    // ---------------- simultaneous I and D: D first, I three cycles later ----------------
    begin
      int dCyc, iCyc;
      bit seen;
      logic [31:0] firstAddr;
      dCyc = -1; iCyc = -1; seen = 0; firstAddr = 0;
      doReset();
      i_req = 1; i_addr = 32'h104; d_re = 1; d_addr = 32'h200; m_rdata = 32'h55AA_55AA;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if ((m_re | m_we) && !seen) begin seen = 1; firstAddr = m_addr; end
        if (d_ready && dCyc < 0) begin dCyc = c; d_re = 0; end
        if (i_ready && iCyc < 0) begin iCyc = c; i_req = 0; end
        m_ready = m_re | m_we;
      end
      m_ready = 0;
      check("both first addr", firstAddr, 32'h200);
      check("both d_ready cycle", dCyc, 2);
      check("both i after d", iCyc - dCyc, 3);
    end

    // ---------------- starvation guard: 4 D writes then 1 I read, repeating ----------------
    begin
      int  nG;
      bit  prevS, s;
      bit  kindD[10];
      nG = 0; prevS = 0;
      doReset();
      d_we = 1; d_addr = 32'h40; d_wdata = 32'hA5A5_A5A5; i_req = 1; i_addr = 32'h80;
      m_rdata = 32'h7777_7777;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        s = m_we | m_re;
        if (s && !prevS && nG < 10) begin
          kindD[nG] = m_we;
          if (m_we) check("starve m_wdata", m_wdata, 32'hA5A5_A5A5);
          else      check("starve i addr", m_addr, 32'h80);
          nG++;
        end
        prevS = s;
        m_ready = s;
      end
      idleInputs();
      check("starve grant count", nG, 10);
      for (int g = 0; g < 10; g++) check("starve order", kindD[g], (g % 5) != 4);
    end

    // ---------------- reset in the second DBUSY cycle, stale m_ready afterwards ----------------
    doReset();
    d_re = 1; d_addr = 32'h220;
    @(negedge clk);
    check("midrst m_re before", m_re, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("midrst m_re", m_re, 0);
    check("midrst m_addr", m_addr, 0);
    check("midrst d_ready", d_ready, 0);
    rst = 1; d_re = 0; m_ready = 1; m_rdata = 32'h3333_3333;
    @(negedge clk);
    check("midrst stale d_ready", d_ready, 0);
    check("midrst stale m_re", m_re, 0);
    @(negedge clk);
    check("midrst stale d_ready2", d_ready, 0);
    check("midrst d_rdata", d_rdata, 0);
    m_ready = 0; i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    check("midrst idle grant", m_re, 1);
    check("midrst idle addr", m_addr, 32'h10);
    m_ready = 1; m_rdata = 32'h77;
    @(negedge clk);
    check("midrst i_ready", i_ready, 1);
    check("midrst i_data", i_data, 32'h77);
    check("midrst no d_ready", d_ready, 0);
    idleInputs();

`ifdef BETA_ARB_TIMEOUT_EN
    // ---------------- watchdog abort ----------------
    doReset();
    i_req = 1; i_addr = 32'h500; m_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("to strobe held", m_re, 1);
      check("to no ready", i_ready, 0);
    end
    @(negedge clk);
    check("to strobe drop", m_re, 0);
    check("to i_ready", i_ready, 1);
    check("to i_data", i_data, 32'hFFFF_FFFF);
    check("to err", err, 1);
    i_req = 0;
    @(negedge clk);
    check("to err sticky", err, 1);
    check("to pulse width", i_ready, 0);
    rst = 0;
    @(negedge clk);
    check("to err cleared", err, 0);
    rst = 1;
`endif

    // ---------------- randomized run vs transaction model ----------------
    doReset();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    iPend = 0; dPend = 0; dWeR = 0; dReR = 0; grantExp = 0; grantDExp = 0;
    accActive = 0; accD = 0; accWe = 0; accAddr = 0; accWd = 0;
    expIP = 0; expDP = 0; iHeld = 0; dHeld = 0; streak = 0; waitLeft = 0;
    iAddrR = 0; dAddrR = 0; dWdR = 0;
    for (int c = 0; c < 2500; c++) begin
      respNow = expIP | expDP;
      check("rnd i_ready", i_ready, expIP);
      check("rnd d_ready", d_ready, expDP);
      check("rnd i_data", i_data, iHeld);
      check("rnd d_rdata", d_rdata, dHeld);
      check("rnd err", err, 0);
      if (expIP) iPend = 0;
      if (expDP) dPend = 0;
      expIP = 0; expDP = 0;
      if (grantExp) begin
        check("rnd grant", m_we | m_re, 1);
        accActive = 1;
        accD = grantDExp;
        waitLeft = $urandom_range(0, 3);
      end
      if (accActive) begin
        check("rnd m_addr", m_addr, accAddr);
        check("rnd m_we", m_we, accWe);
        check("rnd m_re", m_re, !accWe);
        if (accWe) check("rnd m_wdata", m_wdata, accWd);
      end else begin
        check("rnd idle strobes", m_we | m_re, 0);
      end
      busyNow = accActive;
      if (accActive) begin
        if (waitLeft == 0) begin
          m_ready = 1;
          if (accWe) begin
            m_rdata = $urandom;
            mem[accAddr[5:2]] = accWd;
          end else begin
            m_rdata = mem[accAddr[5:2]];
            if (accD) dHeld = m_rdata;
            else      iHeld = m_rdata;
          end
          if (accD) expDP = 1;
          else      expIP = 1;
          accActive = 0;
        end else begin
          waitLeft--;
          m_ready = 0;
          m_rdata = $urandom;
        end
      end else begin
        // stray completions while nothing is outstanding must be ignored
        m_ready = ($urandom_range(0, 3) == 0);
        m_rdata = $urandom;
      end
      idleNow = !busyNow && !respNow;
      if (!iPend && $urandom_range(0, 2) == 0) begin iPend = 1; iAddrR = $urandom; end
      if (!dPend && $urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        dPend = 1; dAddrR = $urandom; dWdR = $urandom;
        dWeR = (op != 1); dReR = (op != 0);
      end
      i_req = iPend; i_addr = iPend ? iAddrR : $urandom;
      d_we = dPend & dWeR; d_re = dPend & dReR;
      d_addr = dPend ? dAddrR : $urandom; d_wdata = dPend ? dWdR : $urandom;
      grantExp = idleNow && (iPend || dPend);
      if (grantExp) begin
        grantDExp = dPend && (!iPend || streak < 4);
        if (grantDExp) begin
          accAddr = dAddrR; accWe = dWeR; accWd = dWdR;
          if (iPend && streak < 4) streak++;
        end else begin
          accAddr = iAddrR; accWe = 0; accWd = 0;
          streak = 0;
        end
      end
      @(negedge clk);
    end
    idleInputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/beta_mem_arbiter.md
Name: beta_mem_arbiter

Overview:
- Shares one backing memory port between the Beta core's instruction-fetch port and its data port.
- Sits between the core's (InstructionAddress/InstructionData/instructionReady) and (DataAddress/DataRead/DataWrite/WriteEnable/ReadEnable/dataReady) interfaces and a single-ported memory with a variable-latency ready handshake.
- Data accesses have priority, with a bounded starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, max consecutive D grants while i_req is pending before I is forced; range 1..15.
- TIMEOUT, 255, m_ready wait limit in cycles; used only with BETA_ARB_TIMEOUT_EN; range 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- i_addr  in  ADDR_W  fetch address.
- i_req  in  1  fetch request; held with i_addr until i_ready.
- i_data  out  DATA_W  fetched word; valid when i_ready=1, held after.
- i_ready  out  1  one-cycle completion pulse for fetch.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_we  in  1  store request.
- d_re  in  1  load request.
- d_rdata  out  DATA_W  load data; valid when d_ready=1, held after.
- d_ready  out  1  one-cycle completion pulse for data access.
- m_addr  out  ADDR_W  memory address (registered).
- m_wdata  out  DATA_W  memory write data (registered).
- m_we  out  1  memory write strobe (registered).
- m_re  out  1  memory read strobe (registered).
- m_rdata  in  DATA_W  memory read data; sampled when m_ready=1.
- m_ready  in  1  memory completion; one cycle per access.
- err  out  1  timeout flag (see Optional Feature).

Behaviour:
- One clock (clk); reset rst is synchronous and active-low.
- Reset (rst=0 at posedge): state=IDLE; all outputs 0 (m_*, i_data, d_data, readies, err); starvation count=0. Reset mid-access aborts it: strobes drop at that edge, no ready pulse is issued, and a later m_ready is ignored.
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE arbitration, with d_req = d_we|d_re:
  - d_req and (!i_req or cnt<STARVE_MAX) -> DBUSY.
  - Else if i_req -> IBUSY.
  - Else stay in IDLE.
- On grant, register m_addr and the strobes; for D also register m_wdata. Strobes are asserted from the cycle after the grant edge.
  - d_we and d_re both high: the access is a write; m_re=0.
  - I grant: m_re=1, m_we=0.
- Starvation count: +1 on a D grant while i_req=1 (saturating at STARVE_MAX); cleared on an I grant; unchanged otherwise.
- IBUSY/DBUSY: m_addr, m_wdata and the strobes are held stable until m_ready=1.
  - On that edge: capture m_rdata into i_data (IBUSY) or d_rdata (DBUSY read); d_rdata is unchanged for a write. Strobes clear; go to RESP.
  - m_ready is ignored in IDLE and RESP.
- RESP: the owner's ready=1 for exactly this cycle; no grant is made; next state is IDLE.
  - Requesters may drop or change their request from the next cycle.
- Minimum latency, with request seen in IDLE at edge 0:
  - Strobes high in cycle 1.
  - m_ready=1 in cycle 1 -> ready pulse in cycle 2.
  - Next grant at edge 3.
  - Back-to-back throughput is 1 access per 3 cycles minimum.
- Simultaneous i_req and d_req with cnt<STARVE_MAX: D wins.
- Requests arriving while busy wait in IDLE; there is no queue.

Optional Feature:
- Macro BETA_ARB_TIMEOUT_EN.
- When defined: a counter runs in IBUSY/DBUSY. If m_ready has not arrived after TIMEOUT cycles with strobes asserted:
  - Abort: strobes clear, owner data is set to all-ones, RESP is entered, and err is set.
  - err is sticky until reset.
- When undefined: no counter logic; the busy state waits indefinitely; err is tied 0.

Test Plan:
- Reset, then i_req=1, i_addr=0x100, m_ready returned in the first strobe cycle with m_rdata=0x12345678 -> m_re=1 with m_addr=0x100 in cycle 1; i_ready=1 and i_data=0x12345678 in cycle 2; all outputs 0 during reset.
- i_req and d_re asserted together, d_addr=0x200 -> D served first (m_addr=0x200), then I; d_ready precedes i_ready by 3 cycles when m_ready is immediate.
- d_we held continuously with d_wdata=0xA5A5A5A5 and i_req held, STARVE_MAX=4 -> exactly 4 D writes (m_we=1, m_wdata=0xA5A5A5A5), then 1 I read, then the count resets.
- m_ready delayed 5 cycles on a d_re -> m_addr/m_re stable for all 5 cycles; single d_ready pulse; d_rdata holds its value after the pulse.
- rst=0 asserted in the second cycle of DBUSY, then released, with a stale m_ready=1 arriving afterwards -> no d_ready pulse; state IDLE; stale m_ready ignored.
- With BETA_ARB_TIMEOUT_EN and TIMEOUT=8, m_ready never asserted on i_req -> strobes drop after 8 cycles; i_ready=1 with i_data=0xFFFFFFFF; err=1 and held until reset.
